// File: rtl/bus_rcv.sv
// bus_rcv: samples a shared tri-state bus whenever BE is asserted, rejects
// samples carrying X/Z, and queues the clean words in a small FIFO for a
// valid/ready consumer. A three-state FSM (IDLE/ACTIVE/FAULT) is exposed on ST.
//
// Handshake: the consumer sees the head word on Q while QV=1; a word is popped
// on every rising CK edge where QV=1 and QR=1. QV never depends on QR, and Q
// holds steady until the word is popped.
module bus_rcv #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         CK,
  input  logic         R,
  input  logic [W-1:0] BUS,
  input  logic         BE,
  input  logic         CLR,
  input  logic         QR,
  output logic [W-1:0] Q,
  output logic         QV,
  output logic [4:0]   CNT,
  output logic [1:0]   ST,
  output logic         ERR,
  output logic         OVF,
  output logic [7:0]   ECNT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACTIVE = 2'b01,
    S_FAULT  = 2'b10
  } state_t;

  state_t         st_q, st_d;
  logic [W-1:0]   cap_q, cap_d;
  logic           cap_v_q, cap_v_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  rd_next;
  logic [4:0]     cnt_q, cnt_d;
  logic [W-1:0]   q_q, q_d;
  logic           err_q, err_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     ecnt_q, ecnt_d;

  logic           dirty;
  logic           clean;
  logic           pop;
  logic           full;
  logic           push_req;
  logic           push;
  logic           ovf_set;

  // Classify the captured word and decide the FIFO operations for this cycle.
  always_comb begin
    // An X or Z bit survives the self-XOR as X, which the case inequality
    // detects in simulation; real hardware only ever carries 0/1, so the
    // check collapses to "clean".
    dirty    = cap_v_q && ((cap_q ^ cap_q) !== '0);
    clean    = cap_v_q && !dirty;
    full     = (cnt_q == 5'(DEPTH));
    pop      = (cnt_q != 5'd0) && QR;
    push_req = clean && (st_q != S_FAULT);
    // A full FIFO can still take a word when the head leaves in the same cycle.
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    rd_next  = rd_ptr_q + AW'(1);
  end

  // Next-state computation for capture stage, FSM, FIFO and status flags.
  always_comb begin
    cap_v_d  = BE;
    cap_d    = BE ? BUS : cap_q;

    st_d = st_q;
    case (st_q)
      S_IDLE:   if (BE) st_d = S_ACTIVE;
      S_ACTIVE: begin
        if (dirty)    st_d = S_FAULT;
        else if (!BE) st_d = S_IDLE;
      end
      S_FAULT:  if (CLR) st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_next : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 5'd1;
    else if (pop && !push) cnt_d = cnt_q - 5'd1;

    // Q mirrors the head word; when the FIFO drains it keeps the last value.
    q_d = q_q;
    if (cnt_d != 5'd0) begin
      if (pop && (cnt_q > 5'd1))                   q_d = mem_q[rd_next];
      else if (pop || (cnt_q == 5'd0))             q_d = cap_q;
    end

    // Set conditions beat CLR so an event in the clearing cycle is not lost.
    err_d = err_q;
    if (dirty)    err_d = 1'b1;
    else if (CLR) err_d = 1'b0;

    ovf_d = ovf_q;
    if (ovf_set)  ovf_d = 1'b1;
    else if (CLR) ovf_d = 1'b0;

    ecnt_d = ecnt_q;
    if (CLR)                             ecnt_d = dirty ? 8'd1 : 8'd0;
    else if (dirty && (ecnt_q != 8'hFF)) ecnt_d = ecnt_q + 8'd1;
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge CK) begin
    if (R) begin
      st_q     <= S_IDLE;
      cap_q    <= '0;
      cap_v_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= 5'd0;
      q_q      <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ecnt_q   <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      st_q     <= st_d;
      cap_q    <= cap_d;
      cap_v_q  <= cap_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      ecnt_q   <= ecnt_d;
      if (push) mem_q[wr_ptr_q] <= cap_q;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Q    = q_q;
    QV   = (cnt_q != 5'd0);
    CNT  = cnt_q;
    ST   = st_q;
    ERR  = err_q;
    OVF  = ovf_q;
    ECNT = ecnt_q;
  end

endmodule

// File: tb/tb_bus_rcv.sv
// tb_bus_rcv: directed scenarios followed by a random phase. A queue-based
// reference model advances on every rising edge; a negedge monitor compares
// the DUT outputs against it and pops expected words as the consumer takes them.
module tb_bus_rcv;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  // Clock/reset and DUT
  logic         ck = 1'b0;
  logic         r, be, clr, qr;
  logic [W-1:0] bus;
  logic [W-1:0] q;
  logic         qv, err, ovf;
  logic [4:0]   cnt;
  logic [1:0]   st;
  logic [7:0]   ecnt;

  always #5 ck = ~ck;

  bus_rcv #(.W(W), .DEPTH(DEPTH)) dut (
    .CK(ck), .R(r), .BUS(bus), .BE(be), .CLR(clr), .QR(qr),
    .Q(q), .QV(qv), .CNT(cnt), .ST(st), .ERR(err), .OVF(ovf), .ECNT(ecnt)
  );

  // Scoreboard state
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  bit           mon_en = 1'b0;
  logic [W-1:0] dirty_pat;

  // Reference model: words in flight are in exp_q, the rest is bookkeeping
  int           m_cnt  = 0;
  int           m_st   = 0;   // 0 idle, 1 active, 2 fault
  int           m_ecnt = 0;
  bit           m_err  = 1'b0;
  bit           m_ovf  = 1'b0;
  bit           m_cap_v = 1'b0;
  logic [W-1:0] m_cap  = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model step on each rising edge using the inputs held across that edge.
  always @(posedge ck) begin
    bit m_dirty, m_clean, m_pop, m_want, m_full;
    if (r) begin
      m_cnt = 0; m_st = 0; m_ecnt = 0; m_err = 0; m_ovf = 0; m_cap_v = 0;
      exp_q.delete();
    end else begin
      m_dirty = m_cap_v && $isunknown(m_cap);
      m_clean = m_cap_v && !m_dirty;
      m_pop   = (m_cnt != 0) && qr;
      m_want  = m_clean && (m_st != 2);
      m_full  = (m_cnt == DEPTH);
      if (m_want && (!m_full || m_pop)) begin
        exp_q.push_back(m_cap);
        m_cnt++;
      end
      if (m_pop) m_cnt--;
      if (m_want && m_full && !m_pop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (m_dirty) m_err = 1;
      else if (clr) m_err = 0;
      if (clr) m_ecnt = m_dirty ? 1 : 0;
      else if (m_dirty) m_ecnt = (m_ecnt + 1 > 255) ? 255 : m_ecnt + 1;
      if (m_st == 0 && be) m_st = 1;
      else if (m_st == 1 && m_dirty) m_st = 2;
      else if (m_st == 1 && !be) m_st = 0;
      else if (m_st == 2 && clr) m_st = 0;
      m_cap_v = be;
      if (be) m_cap = bus;
    end
  end

  // Monitor: compare visible state, then consume the head word on a handshake.
  always @(negedge ck) begin
    if (mon_en) begin
      chk("cnt",  32'(cnt),  32'(m_cnt));
      chk("st",   32'(st),   32'(m_st));
      chk("err",  32'(err),  32'(m_err));
      chk("ovf",  32'(ovf),  32'(m_ovf));
      chk("ecnt", 32'(ecnt), 32'(m_ecnt));
      chk("qv",   32'(qv),   32'(m_cnt != 0));
      if (qv) begin
        if (exp_q.size() == 0) chk("q_unexpected", 32'(q), 32'hFFFF_FFFF);
        else begin
          chk("q", 32'(q), 32'(exp_q[0]));
          if (qr) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver: hold the inputs across exactly one rising edge.
  task automatic drive(input bit b, input logic [W-1:0] d, input bit rdy,
                       input bit c, input bit rst);
    be = b; bus = d; qr = rdy; clr = c; r = rst;
    @(posedge ck);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    dirty_pat = 8'bxxxx_0000;
    r = 1'b1; be = 1'b0; clr = 1'b0; qr = 1'b0; bus = '0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_q", 32'(q), 32'h0);
    mon_en = 1'b1;

    // Single word with consumer ready
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Six words into a four-deep FIFO, then drain
    for (int i = 1; i <= 6; i++) drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Full FIFO with pop and push in the same cycle
    for (int i = 0; i < 5; i++) drive(1'b1, W'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Dirty sample, following clean word ignored, then CLR
    drive(1'b1, dirty_pat, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Saturate the error counter, then a dirty sample landing with CLR
    for (int i = 0; i < 300; i++) drive(1'b1, dirty_pat, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    drive(1'b1, dirty_pat, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Reset in the middle of a burst with three words queued
    for (int i = 0; i < 4; i++) drive(1'b1, W'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
    chk("midrst_q", 32'(q), 32'h0);
    drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if ($urandom_range(0, 19) == 0) d = dirty_pat;
      drive($urandom_range(0, 9) < 7, d, 1'($urandom_range(0, 1)),
            $urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
    end
    idle(8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rcv.md
BUS_RCV -- requirements
Module: bus_rcv

Interface
REQ-001 SHALL have parameter W, default 8, giving the bus data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the receive FIFO depth in words (power of two, 2..16).
REQ-003 SHALL have port CK  input  1  as its single clock; all state updates on posedge CK.
REQ-004 SHALL have port R  input  1  as its reset; reset is synchronous and active-high.
REQ-005 SHALL have port BUS  input  W  as the shared tri-state bus, driven by tribuf-style drivers.
REQ-006 SHALL have port BE  input  1  as the bus-enable strobe; high when exactly one driver is enabled.
REQ-007 SHALL have port CLR  input  1  to clear the sticky flags, the error counter and the FAULT state.
REQ-008 SHALL have port QR  input  1  as the consumer ready.
REQ-009 SHALL have port Q  output  W  as the FIFO head word.
REQ-010 SHALL have port QV  output  1  as the valid flag for Q.
REQ-011 SHALL have port CNT  output  5  as the FIFO occupancy, 0..DEPTH.
REQ-012 SHALL have port ST  output  2  as the FSM state: 00 IDLE, 01 ACTIVE, 10 FAULT.
REQ-013 SHALL have port ERR  output  1  as the sticky dirty-sample flag.
REQ-014 SHALL have port OVF  output  1  as the sticky FIFO-overflow flag.
REQ-015 SHALL have port ECNT  output  8  as the dirty-sample count, saturating.

Function
REQ-016 SHALL register BUS into a capture stage at each posedge CK where BE=1, marking the stage valid; the stage is invalid when BE=0.
REQ-017 SHALL classify a valid capture as dirty if any bit is X or Z (simulation model, case-equality check), and as clean otherwise.
REQ-018 SHALL, on the edge after capture, push a clean word into the FIFO when ST is not FAULT; total latency is BE edge n -> QV=1 and Q=word after edge n+1.
REQ-019 SHALL discard a dirty word, set ERR=1 and increment ECNT, with ECNT saturating at 255.
REQ-020 SHALL discard all captures, clean or dirty, while ST=FAULT; dirty captures in FAULT still increment ECNT.
REQ-021 SHALL implement FSM transitions: IDLE->ACTIVE on BE=1; ACTIVE->IDLE on BE=0; ACTIVE->FAULT on a dirty capture; FAULT->IDLE on CLR=1.
REQ-022 SHALL drop a clean push when the FIFO is full and no pop occurs in the same cycle, and set OVF=1.
REQ-023 SHALL accept both operations when a pop and a push coincide while full, leaving CNT unchanged and OVF unaffected.
REQ-024 SHALL pop the head word on a cycle where QV=1 and QR=1; QV=(CNT!=0); Q holds the head word, or its last value when empty.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH, preserving FIFO order across wrap.
REQ-026 SHALL clear ERR, OVF and ECNT on CLR=1; a dirty capture or overflow in the same cycle wins, leaving the flag set and ECNT=1.
REQ-027 SHALL keep the FIFO contents and the QV/QR handshake unaffected by CLR.

Reset
REQ-028 SHALL, when R=1 at posedge CK, set Q=0, QV=0, CNT=0, ST=IDLE, ERR=0, OVF=0, ECNT=0, invalidate the capture stage and empty the FIFO.
REQ-029 SHALL give R priority over all other inputs; a word captured in the reset cycle or in the cycle before it is lost.

Verification
REQ-030 SHALL pass: BE=1 with BUS=8'hA5 for one edge, QR=1 -> QV=1, Q=A5 after the next edge; QV=0 one edge later.
REQ-031 SHALL pass: QR=0, six consecutive clean words 01..06 -> CNT=4, OVF=1, and popping yields 01,02,03,04.
REQ-032 SHALL pass: BE=1 with BUS=8'bzzzz_0000 -> ERR=1, ECNT=1, ST=FAULT; a following clean word is not queued; CLR=1 -> ST=IDLE, ERR=0.
REQ-033 SHALL pass: FIFO full, with QR=1 and a clean push in the same cycle -> CNT stays 4, OVF=0, and order is preserved.
REQ-034 SHALL pass: 300 dirty samples -> ECNT=255 (saturated).
REQ-035 SHALL pass: R=1 asserted mid-burst with CNT=3 -> all outputs at reset values after that edge; with BE held high, ST=ACTIVE on the next edge.
